// File: rtl/bit_accum_ctrl_if.sv
// ---------------------------------------------------------------------------
// bit_accum_ctrl_if
//  Handshake/bus bundle between the SMAC operand streamer, the lane bit
//  register and the bit_accum_ctrl sequencer. Clock and reset are kept as
//  plain ports on the modules that use this bundle.
//
//  master : operand streamer / downstream side (drives start, abort,
//           in_valid, out_ready; observes everything else)
//  slave  : bit_accum_ctrl sequencer
//
//  Signals
//   start      request new operation
//   abort      synchronous cancel of the current operation
//   in_valid   upstream bit-plane beat valid
//   in_ready   sequencer accepts a beat this cycle
//   cl_en      clear strobe to the bit register
//   w_en       write strobe to the bit register
//   bit_idx    plane index of the beat being accepted (MSB = NBITS-1)
//   last_bit   high while bit_idx == 0 during accumulation
//   busy       sequencer not idle
//   out_valid  lane result in the bit register is final
//   out_ready  downstream accepts the result
//   done       one-cycle pulse after the output handshake
//   op_cnt     completed-operation count (wraps)
// ---------------------------------------------------------------------------
interface bit_accum_ctrl_if #(
  parameter int NBITS = 8,
  parameter int CNTW  = 16
);
  localparam int IDXW = (NBITS > 1) ? $clog2(NBITS) : 1;

  logic            start;
  logic            abort;
  logic            in_valid;
  logic            in_ready;
  logic            cl_en;
  logic            w_en;
  logic [IDXW-1:0] bit_idx;
  logic            last_bit;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic            done;
  logic [CNTW-1:0] op_cnt;

  modport master (
    output start, abort, in_valid, out_ready,
    input  in_ready, cl_en, w_en, bit_idx, last_bit, busy, out_valid, done, op_cnt
  );

  modport slave (
    input  start, abort, in_valid, out_ready,
    output in_ready, cl_en, w_en, bit_idx, last_bit, busy, out_valid, done, op_cnt
  );
endinterface

// File: rtl/bit_accum_ctrl.sv
// ---------------------------------------------------------------------------
// bit_accum_ctrl
//  Sequencer for one bit-serial accumulation lane. Clears the lane's bit
//  register, admits NBITS bit-plane beats MSB-first, pulsing the register
//  write enable once per accepted beat, then presents the finished result
//  downstream through a valid/ready handshake.
//
//  Parameters
//   M      bit-adder inputs (lane register width $clog2(M)+1, not used here)
//   NBITS  bit planes per operation, 2..256
//   CNTW   width of the completed-operation counter
//
//  Ports
//   clk  in   clock, all state on the rising edge
//   rst  in   asynchronous active-high reset
//   bus  slave modport of bit_accum_ctrl_if (start/abort/in_valid/out_ready
//        in; in_ready/cl_en/w_en/bit_idx/last_bit/busy/out_valid/done/op_cnt
//        out)
// ---------------------------------------------------------------------------
module bit_accum_ctrl #(
  parameter int M     = 16,
  parameter int NBITS = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  bit_accum_ctrl_if.slave  bus
);
  localparam int IDXW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(NBITS - 1);

  // Elaboration-time guard on the parameter ranges.
  generate
    if ((NBITS < 2) || (NBITS > 256) || (M < 1)) begin : g_bad_param
      $error("bit_accum_ctrl: illegal parameters (NBITS must be 2..256, M >= 1)");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_ACCUM = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [IDXW-1:0] bit_idx_reg, bit_idx_next;
  logic [CNTW-1:0] op_cnt_reg, op_cnt_next;
  logic            done_reg, done_next;

  logic in_ready_c;
  logic cl_en_c;
  logic w_en_c;
  logic last_bit_c;
  logic busy_c;
  logic out_valid_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      bit_idx_reg <= '0;
      op_cnt_reg  <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_idx_reg <= bit_idx_next;
      op_cnt_reg  <= op_cnt_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    op_cnt_next  = op_cnt_reg;
    done_next    = 1'b0;
    in_ready_c   = 1'b0;
    cl_en_c      = 1'b0;
    w_en_c       = 1'b0;
    last_bit_c   = 1'b0;
    out_valid_c  = 1'b0;
    busy_c       = (state_reg != S_IDLE);

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cl_en_c      = 1'b1;
        bit_idx_next = IDX_MAX;
        state_next   = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready_c = 1'b1;
        last_bit_c = (bit_idx_reg == '0);
        // Write strobe follows the beat in the same cycle it is presented.
        w_en_c     = bus.in_valid;
        if (bus.in_valid) begin
          if (bit_idx_reg != '0) begin
            bit_idx_next = bit_idx_reg - IDXW'(1);
          end else begin
            state_next = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          done_next   = 1'b1;
          op_cnt_next = op_cnt_reg + CNTW'(1);
          // A start on the handshake cycle chains straight into the next clear.
          state_next  = bus.start ? S_CLEAR : S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE: drop back to IDLE, wipe the
    // partial result in the bit register, and suppress any write or completion.
    if (bus.abort && (state_reg != S_IDLE)) begin
      state_next   = S_IDLE;
      bit_idx_next = bit_idx_reg;
      op_cnt_next  = op_cnt_reg;
      done_next    = 1'b0;
      cl_en_c      = 1'b1;
      w_en_c       = 1'b0;
      in_ready_c   = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.cl_en     = cl_en_c;
  assign bus.w_en      = w_en_c;
  assign bus.bit_idx   = bit_idx_reg;
  assign bus.last_bit  = last_bit_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_c;
  assign bus.done      = done_reg;
  assign bus.op_cnt    = op_cnt_reg;
endmodule
